if_stage_fq: RTL and testbench

- Parametrised next-generation instruction-fetch stage. Replaces the single-entry fetch with a decoupled fetch queue of configurable depth.
- Uses a valid/ready icache request handshake with one request outstanding, and a registered response path.
- Supports redirect/flush with stale-response dropping. Halts after a front-end exception.
- Sits between the branch predictor / icache and the decode stage.

---
 rtl/if_stage_fq.sv | 216 +++++++++++++++++++++
 tb/tb_if_stage_fq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_fq.sv
// Instruction-fetch stage with a decoupled fetch queue.
//
// A single outstanding icache request (valid/ready) is tracked by an in-flight
// register; responses are written into a FQ_DEPTH-entry circular queue whose
// head drives the decode-facing fetch_* outputs. A queue slot is reserved when
// a request issues, so the queue can never overflow. Redirects flush the queue
// and, if a response is still outstanding, the stale response is dropped.
// Any front-end exception (misaligned PC, out-of-range PC, icache page fault)
// is pushed as an exception entry and fetch halts until the next redirect.
//
// Optional build macro: IF_STAGE_FQ_BYPASS_EN -- with the queue empty, a
// response that decode can take in the same cycle is forwarded combinationally
// on the fetch_* outputs instead of being written into the queue.
//
// Ports:
//   clk_i, rstn_i             clock, asynchronous active-low reset
//   reset_addr_i              boot PC (zero-extended to XLEN)
//   redirect_valid_i/pc_i     flush + jump from execute/commit
//   bp_taken_i/target_i       predictor result for the current request PC
//   req_valid_o/ready_i       icache request handshake, req_vaddr_o address
//   resp_valid_i/data_i/fault_i  icache response
//   fetch_*                   queue head towards decode, fetch_ready_i pops
//   fq_count_o                queue occupancy

module if_stage_fq #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned VADDR_SIZE = 40,
  parameter int unsigned FQ_DEPTH   = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [VADDR_SIZE-1:0]         reset_addr_i,
  input  logic                          redirect_valid_i,
  input  logic [XLEN-1:0]               redirect_pc_i,
  input  logic                          bp_taken_i,
  input  logic [XLEN-1:0]               bp_target_i,
  output logic                          req_valid_o,
  input  logic                          req_ready_i,
  output logic [VADDR_SIZE-1:0]         req_vaddr_o,
  input  logic                          resp_valid_i,
  input  logic [31:0]                   resp_data_i,
  input  logic                          resp_fault_i,
  output logic                          fetch_valid_o,
  input  logic                          fetch_ready_i,
  output logic [XLEN-1:0]               fetch_pc_o,
  output logic [31:0]                   fetch_instr_o,
  output logic                          fetch_pred_taken_o,
  output logic [XLEN-1:0]               fetch_pred_target_o,
  output logic                          fetch_ex_valid_o,
  output logic [XLEN-1:0]               fetch_ex_cause_o,
  output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count_o
);

  localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int unsigned HI_W  = XLEN - VADDR_SIZE + 1;

  localparam logic [XLEN-1:0] CAUSE_MISALIGNED = XLEN'(0);
  localparam logic [XLEN-1:0] CAUSE_ACCESS     = XLEN'(1);
  localparam logic [XLEN-1:0] CAUSE_PAGE       = XLEN'(12);

  typedef enum logic [1:0] {IDLE, WAIT, DROP, HALT} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic [XLEN-1:0] ex_cause;
  } fq_entry_t;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    infl_pc_q;
  logic               infl_taken_q;
  logic [XLEN-1:0]    infl_target_q;

  fq_entry_t          mem_q [FQ_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               misaligned, addr_fault, pc_fault, slot_free;
  logic               issue, q_pop, push, bypass;
  logic [HI_W-1:0]    pc_hi;
  fq_entry_t          push_entry, resp_entry, head;

  // PC fault classification and request issue
  assign pc_hi      = pc_q[XLEN-1:VADDR_SIZE-1];
  assign misaligned = (pc_q[1:0] != 2'b00);
  assign addr_fault = !((&pc_hi) || (~|pc_hi));
  assign pc_fault   = misaligned || addr_fault;
  assign slot_free  = (cnt_q < CNT_W'(FQ_DEPTH));

  // Gated by rstn_i so no request is advertised while reset is held
  assign req_valid_o = rstn_i && (state_q == IDLE) && !pc_fault &&
                       !redirect_valid_i && slot_free;
  assign req_vaddr_o = pc_q[VADDR_SIZE-1:0];
  assign issue       = req_valid_o && req_ready_i;

  // Queue pop; a redirect flushes, so a same-cycle pop is discarded
  assign q_pop = (cnt_q != '0) && fetch_ready_i && !redirect_valid_i;

`ifdef IF_STAGE_FQ_BYPASS_EN
  assign bypass = (cnt_q == '0) && (state_q == WAIT) && resp_valid_i &&
                  fetch_ready_i && !redirect_valid_i;
`else
  assign bypass = 1'b0;
`endif

  // Entry built from the current icache response
  always_comb begin
    resp_entry             = '0;
    resp_entry.pc          = infl_pc_q;
    resp_entry.instr       = resp_data_i;
    resp_entry.pred_taken  = infl_taken_q;
    resp_entry.pred_target = infl_target_q;
    resp_entry.ex_valid    = resp_fault_i;
    resp_entry.ex_cause    = CAUSE_PAGE;
  end

  // Next-state, next-PC and queue-push decode
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    push       = 1'b0;
    push_entry = resp_entry;
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
      // A response still owed by the icache must be discarded when it arrives
      if (((state_q == WAIT) || (state_q == DROP)) && !resp_valid_i) begin
        state_d = DROP;
      end else begin
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pc_fault) begin
            if (slot_free) begin
              push                   = 1'b1;
              push_entry             = '0;
              push_entry.pc          = pc_q;
              push_entry.ex_valid    = 1'b1;
              push_entry.ex_cause    = misaligned ? CAUSE_MISALIGNED : CAUSE_ACCESS;
              state_d                = HALT;
            end
          end else if (issue) begin
            pc_d    = bp_taken_i ? bp_target_i : pc_q + XLEN'(4);
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (resp_valid_i) begin
            push    = !bypass;
            state_d = resp_fault_i ? HALT : IDLE;
          end
        end
        DROP: begin
          if (resp_valid_i) state_d = IDLE;
        end
        HALT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state, PC, in-flight request and queue pointers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      pc_q          <= XLEN'(reset_addr_i);
      infl_pc_q     <= '0;
      infl_taken_q  <= 1'b0;
      infl_target_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (issue) begin
        infl_pc_q     <= pc_q;
        infl_taken_q  <= bp_taken_i;
        infl_target_q <= bp_target_i;
      end
      if (redirect_valid_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (q_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (push && !q_pop)      cnt_q <= cnt_q + CNT_W'(1);
        else if (!push && q_pop) cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Queue storage; contents are only observed when the entry is counted valid
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  // Head of queue (or forwarded response) towards decode
  assign head                = bypass ? resp_entry : mem_q[rd_ptr_q];
  assign fetch_valid_o       = (cnt_q != '0) || bypass;
  assign fetch_pc_o          = head.pc;
  assign fetch_instr_o       = head.instr;
  assign fetch_pred_taken_o  = head.pred_taken;
  assign fetch_pred_target_o = head.pred_target;
  assign fetch_ex_valid_o    = head.ex_valid;
  assign fetch_ex_cause_o    = head.ex_cause;
  assign fq_count_o          = cnt_q;

endmodule

// File: tb/tb_if_stage_fq.sv
// Directed bench for if_stage_fq (default build, FQ_DEPTH = 4).
module tb_if_stage_fq;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [39:0] reset_addr_i;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        bp_taken_i;
  logic [63:0] bp_target_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [39:0] req_vaddr_o;
  logic        resp_valid_i;
  logic [31:0] resp_data_i;
  logic        resp_fault_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [63:0] fetch_pc_o;
  logic [31:0] fetch_instr_o;
  logic        fetch_pred_taken_o;
  logic [63:0] fetch_pred_target_o;
  logic        fetch_ex_valid_o;
  logic [63:0] fetch_ex_cause_o;
  logic [2:0]  fq_count_o;

  if_stage_fq dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .reset_addr_i(reset_addr_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .bp_taken_i(bp_taken_i), .bp_target_i(bp_target_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_vaddr_o(req_vaddr_o),
    .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i), .resp_fault_i(resp_fault_i),
    .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready_i),
    .fetch_pc_o(fetch_pc_o), .fetch_instr_o(fetch_instr_o),
    .fetch_pred_taken_o(fetch_pred_taken_o), .fetch_pred_target_o(fetch_pred_target_o),
    .fetch_ex_valid_o(fetch_ex_valid_o), .fetch_ex_cause_o(fetch_ex_cause_o),
    .fq_count_o(fq_count_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  logic        auto_resp;
  logic        fault_next;
  logic [39:0] req_log [$];

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [39:0] va;
    logic        fv;
    logic [63:0] fpc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs [17];

  function automatic logic [31:0] mk_instr(input logic [39:0] a);
    return {a[31:2], 2'b11};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: record a handshake, then model a 1-cycle icache if enabled
  task automatic tick();
    logic        hs;
    logic [39:0] a;
    #1;
    hs = req_valid_o && req_ready_i;
    a  = req_vaddr_o;
    @(posedge clk_i);
    #1;
    if (hs) req_log.push_back(a);
    if (auto_resp) begin
      resp_valid_i = hs;
      resp_data_i  = mk_instr(a);
      resp_fault_i = hs && fault_next;
    end
    #1;
  endtask

  task automatic do_reset(input logic [39:0] addr);
    rstn_i           = 1'b0;
    reset_addr_i     = addr;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    bp_taken_i       = 1'b0;
    bp_target_i      = '0;
    req_ready_i      = 1'b1;
    resp_valid_i     = 1'b0;
    resp_data_i      = '0;
    resp_fault_i     = 1'b0;
    fetch_ready_i    = 1'b1;
    auto_resp        = 1'b1;
    fault_next       = 1'b0;
    req_log.delete();
    @(posedge clk_i);
    #3;
    chk("reset req_valid", 64'(req_valid_o), 64'd0);
    chk("reset fetch_valid", 64'(fetch_valid_o), 64'd0);
    chk("reset count", 64'(fq_count_o), 64'd0);
    chk("reset vaddr", 64'(req_vaddr_o), 64'(addr));
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [63:0] pc, input logic [31:0] instr,
                          input logic ex, input logic [63:0] cause);
    chk({tag, " fetch_valid"}, 64'(fetch_valid_o), 64'd1);
    chk({tag, " fetch_pc"}, fetch_pc_o, pc);
    chk({tag, " fetch_instr"}, 64'(fetch_instr_o), 64'(instr));
    chk({tag, " ex_valid"}, 64'(fetch_ex_valid_o), 64'(ex));
    if (ex) chk({tag, " ex_cause"}, fetch_ex_cause_o, cause);
  endtask

  initial begin
    // rdy, req_valid, vaddr, fetch_valid, fetch_pc, count
    vecs[0]  = '{1'b1, 1'b1, 40'h80000000, 1'b0, 64'h0,        3'd0};
    vecs[1]  = '{1'b1, 1'b0, 40'h80000004, 1'b0, 64'h0,        3'd0};
    vecs[2]  = '{1'b1, 1'b1, 40'h80000004, 1'b1, 64'h80000000, 3'd1};
    vecs[3]  = '{1'b1, 1'b0, 40'h80000008, 1'b0, 64'h0,        3'd0};
    vecs[4]  = '{1'b1, 1'b1, 40'h80000008, 1'b1, 64'h80000004, 3'd1};
    vecs[5]  = '{1'b1, 1'b0, 40'h8000000C, 1'b0, 64'h0,        3'd0};
    vecs[6]  = '{1'b0, 1'b1, 40'h8000000C, 1'b1, 64'h80000008, 3'd1};
    vecs[7]  = '{1'b0, 1'b0, 40'h80000010, 1'b1, 64'h80000008, 3'd1};
    vecs[8]  = '{1'b0, 1'b1, 40'h80000010, 1'b1, 64'h80000008, 3'd2};
    vecs[9]  = '{1'b0, 1'b0, 40'h80000014, 1'b1, 64'h80000008, 3'd2};
    vecs[10] = '{1'b0, 1'b1, 40'h80000014, 1'b1, 64'h80000008, 3'd3};
    vecs[11] = '{1'b0, 1'b0, 40'h80000018, 1'b1, 64'h80000008, 3'd3};
    vecs[12] = '{1'b0, 1'b0, 40'h80000018, 1'b1, 64'h80000008, 3'd4};
    vecs[13] = '{1'b1, 1'b0, 40'h80000018, 1'b1, 64'h80000008, 3'd4};
    vecs[14] = '{1'b1, 1'b1, 40'h80000018, 1'b1, 64'h8000000C, 3'd3};
    vecs[15] = '{1'b1, 1'b0, 40'h8000001C, 1'b1, 64'h80000010, 3'd2};
    vecs[16] = '{1'b1, 1'b1, 40'h8000001C, 1'b1, 64'h80000014, 3'd2};

    // Sequential fetch, then back-pressure until the queue is full, then release
    do_reset(40'h80000000);
    for (int i = 0; i < 17; i++) begin
      fetch_ready_i = vecs[i].rdy;
      #1;
      chk($sformatf("row%0d req_valid", i), 64'(req_valid_o), 64'(vecs[i].rv));
      chk($sformatf("row%0d vaddr", i), 64'(req_vaddr_o), 64'(vecs[i].va));
      chk($sformatf("row%0d fetch_valid", i), 64'(fetch_valid_o), 64'(vecs[i].fv));
      chk($sformatf("row%0d count", i), 64'(fq_count_o), 64'(vecs[i].cnt));
      if (vecs[i].fv) begin
        chk($sformatf("row%0d fetch_pc", i), fetch_pc_o, vecs[i].fpc);
        chk($sformatf("row%0d instr", i), 64'(fetch_instr_o), 64'(mk_instr(vecs[i].fpc[39:0])));
        chk($sformatf("row%0d ex_valid", i), 64'(fetch_ex_valid_o), 64'd0);
      end
      tick();
    end
    chk("req_log size", 64'(req_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < req_log.size(); i++)
      chk($sformatf("req_log[%0d]", i), 64'(req_log[i]), 64'h80000000 + 64'(4 * i));

    // Predicted-taken request
    do_reset(40'h1000);
    fetch_ready_i = 1'b0;
    bp_taken_i    = 1'b1;
    bp_target_i   = 64'h2000;
    #1;
    chk("bp req_valid", 64'(req_valid_o), 64'd1);
    chk("bp vaddr0", 64'(req_vaddr_o), 64'h1000);
    tick();
    bp_taken_i = 1'b0;
    #1;
    chk("bp vaddr1", 64'(req_vaddr_o), 64'h2000);
    tick();
    #1;
    chk_head("bp head", 64'h1000, mk_instr(40'h1000), 1'b0, 64'd0);
    chk("bp pred_taken", 64'(fetch_pred_taken_o), 64'd1);
    chk("bp pred_target", fetch_pred_target_o, 64'h2000);
    chk("bp req 2000", 64'(req_valid_o), 64'd1);

    // Redirect while a request to 0x2000 is outstanding; its response is dropped
    auto_resp = 1'b0;
    tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h3000;
    #1;
    chk("redir req_valid", 64'(req_valid_o), 64'd0);
    tick();
    redirect_valid_i = 1'b0;
    #1;
    chk("flush fetch_valid", 64'(fetch_valid_o), 64'd0);
    chk("flush count", 64'(fq_count_o), 64'd0);
    chk("drop req_valid a", 64'(req_valid_o), 64'd0);
    tick();
    #1;
    chk("drop req_valid b", 64'(req_valid_o), 64'd0);
    resp_valid_i = 1'b1;
    resp_data_i  = 32'hDEADBEEF;
    tick();
    resp_valid_i = 1'b0;
    #1;
    chk("drop count", 64'(fq_count_o), 64'd0);
    chk("after drop req_valid", 64'(req_valid_o), 64'd1);
    chk("after drop vaddr", 64'(req_vaddr_o), 64'h3000);
    auto_resp     = 1'b1;
    fetch_ready_i = 1'b1;
    tick();
    tick();
    #1;
    chk_head("redir head", 64'h3000, mk_instr(40'h3000), 1'b0, 64'd0);

    // Misaligned redirect target
    auto_resp        = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h3002;
    tick();
    redirect_valid_i = 1'b0;
    #1;
    chk("mis req_valid", 64'(req_valid_o), 64'd0);
    chk("mis count0", 64'(fq_count_o), 64'd0);
    tick();
    #1;
    chk_head("mis head", 64'h3002, 32'h0, 1'b1, 64'd0);
    tick();
    fetch_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("halt%0d req_valid", i), 64'(req_valid_o), 64'd0);
      chk($sformatf("halt%0d count", i), 64'(fq_count_o), 64'd0);
      tick();
    end

    // Out-of-range PC
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h0000_0100_0000_0000;
    tick();
    redirect_valid_i = 1'b0;
    tick();
    #1;
    chk_head("acc head", 64'h0000_0100_0000_0000, 32'h0, 1'b1, 64'd1);
    chk("acc req_valid", 64'(req_valid_o), 64'd0);
    chk("acc count", 64'(fq_count_o), 64'd1);

    // Page fault reported on the icache response
    auto_resp        = 1'b1;
    fault_next       = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h4000;
    tick();
    redirect_valid_i = 1'b0;
    #1;
    chk("pf count0", 64'(fq_count_o), 64'd0);
    chk("pf req_valid", 64'(req_valid_o), 64'd1);
    chk("pf vaddr", 64'(req_vaddr_o), 64'h4000);
    tick();
    tick();
    fault_next = 1'b0;
    #1;
    chk_head("pf head", 64'h4000, mk_instr(40'h4000), 1'b1, 64'd12);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("pf halt%0d req_valid", i), 64'(req_valid_o), 64'd0);
      chk($sformatf("pf halt%0d count", i), 64'(fq_count_o), 64'd1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
